// File: rtl/uart_rx_pkg.sv
// Shared UART RX types: bit-timer state encoding and configuration limits.
// Pure declarations, no timing or flow control of its own.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int MIN_PRESCALE_3S = 4;
    localparam int MIN_PRESCALE_1S = 2;
    localparam int MIN_FRAME_BITS  = 2;

    // Three taps at M-1..M+1 need M >= 2 so the first tap is not edge 0.
    function automatic int min_prescale(input int samples);
        return (samples == 3) ? MIN_PRESCALE_3S : MIN_PRESCALE_1S;
    endfunction

endpackage

// File: rtl/rx_majority_vote.sv
// Three-tap capture with 2-of-3 vote; result and valid registered one cycle after the last tap.
// No backpressure: valid is a single-cycle pulse the consumer must take.
module rx_majority_vote (
    input  logic clk,
    input  logic rst,
    input  logic capture,
    input  logic last,
    input  logic rx_in,
    output logic voted,
    output logic valid
);

    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist  <= '0;
            voted <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (capture) begin
                hist <= {hist[0], rx_in};
                // The third tap is voted directly from the line, not from hist.
                if (last) begin
                    voted <= (hist[1] & hist[0]) | (hist[1] & rx_in) | (hist[0] & rx_in);
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART RX oversampling bit timer: edge/bit counters, frame tracking, mid-bit voted sample.
// Pulses decoded from registered state; sample_valid one cycle after last tap; no backpressure.
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4,
    parameter int SAMPLES    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    input  logic                  rx_in,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_err
);

    localparam int MIN_P = min_prescale(SAMPLES);

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] edge_q, edge_nxt;
    logic [BIT_CNT_W-1:0]  bit_q, bit_nxt;
    logic [PRESCALE_W-1:0] p_lat;
    logic [BIT_CNT_W-1:0]  f_lat;
    logic                  latch_cfg;
    logic                  cfg_bad;
    logic                  last_edge;
    logic                  last_bit;
    logic                  in_count;
    logic [PRESCALE_W-1:0] mid;

    assign cfg_bad   = (prescale < PRESCALE_W'(MIN_P)) ||
                       (frame_bits < BIT_CNT_W'(MIN_FRAME_BITS));
    assign in_count  = (state == ST_COUNT);
    assign last_edge = (edge_q == p_lat - PRESCALE_W'(1));
    assign last_bit  = (bit_q == f_lat - BIT_CNT_W'(1));
    assign mid       = p_lat >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            edge_q <= '0;
            bit_q  <= '0;
            p_lat  <= '0;
            f_lat  <= '0;
        end else begin
            state  <= state_nxt;
            edge_q <= edge_nxt;
            bit_q  <= bit_nxt;
            if (latch_cfg) begin
                p_lat <= prescale;
                f_lat <= frame_bits;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_q;
        bit_nxt   = bit_q;
        latch_cfg = 1'b0;
        case (state)
            ST_IDLE: begin
                edge_nxt = '0;
                bit_nxt  = '0;
                if (enable) begin
                    latch_cfg = 1'b1;
                    state_nxt = cfg_bad ? ST_ERR : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    edge_nxt  = '0;
                    bit_nxt   = '0;
                end else if (last_edge) begin
                    // Final edge of the frame leaves counters parked for the consumer to read.
                    if (last_bit) begin
                        state_nxt = ST_DONE;
                    end else begin
                        edge_nxt = '0;
                        bit_nxt  = bit_q + BIT_CNT_W'(1);
                    end
                end else begin
                    edge_nxt = edge_q + PRESCALE_W'(1);
                end
            end
            default: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    edge_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
        endcase
    end

    assign edge_count = edge_q;
    assign bit_count  = bit_q;
    assign bit_done   = in_count && last_edge;
    assign frame_done = bit_done && last_bit;
    assign cfg_err    = (state == ST_ERR);

    generate
        if (SAMPLES == 3) begin : g_vote3
            logic cap;
            logic cap_last;

            assign cap      = in_count && ((edge_q == mid - PRESCALE_W'(1)) ||
                                           (edge_q == mid) ||
                                           (edge_q == mid + PRESCALE_W'(1)));
            assign cap_last = in_count && (edge_q == mid + PRESCALE_W'(1));

            rx_majority_vote u_vote (
                .clk     (clk),
                .rst     (rst),
                .capture (cap),
                .last    (cap_last),
                .rx_in   (rx_in),
                .voted   (sampled_bit),
                .valid   (sample_valid)
            );
        end else begin : g_vote1
            logic bit_q1;
            logic vld_q1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    bit_q1 <= 1'b0;
                    vld_q1 <= 1'b0;
                end else begin
                    vld_q1 <= 1'b0;
                    if (in_count && (edge_q == mid)) begin
                        bit_q1 <= rx_in;
                        vld_q1 <= 1'b1;
                    end
                end
            end

            assign sampled_bit  = bit_q1;
            assign sample_valid = vld_q1;
        end
    endgenerate

endmodule
